ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 contral_out_b1  input  7  ID/EX control: [6]=ALU_src, [5]=Reg_dst, [4]=Reg_w, [3]=Mem_w, [2]=Mem_r, [1:0]=ALU_op.
REQ-004 RsData_b, RtData_b1  input  32 each  ID/EX register-file operands.
REQ-005 ALU_something  input  16  immediate field; [5:0] is funct.
REQ-006 RdAddr_b1, RtAddr_b, RsAddr_b  input  5 each  register addresses.
REQ-007 wb_reg_w  input  1; wb_addr  input  5; wb_data  input  32  MEM/WB write-back used for forwarding.
REQ-008 ex_busy  output  1  stall request to upstream; ID/EX and earlier stages hold while high.
REQ-009 mem_ctrl  output  3  registered {Reg_w, Mem_w, Mem_r}.
REQ-010 alu_result  output  32  registered ALU or multiply result.
REQ-011 store_data  output  32  registered forwarded Rt value.
REQ-012 dst_addr  output  5  registered destination register.
REQ-013 zero_flag  output  1  registered (ALU result == 0).

Function
REQ-014 Forward A/B SHALL select, in priority order: internal EX/MEM result if mem_ctrl[2]=1, dst_addr!=0 and dst_addr matches; else wb_data if wb_reg_w=1, wb_addr!=0 and matches; else the register-file operand.
REQ-015 Operand B SHALL be the sign-extended ALU_something when ALU_src=1, else forwarded Rt.
REQ-016 ALU_op 00 = add; 01 = sub; 11 = slt (signed, result 0 or 1); 10 = decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 011000 mult (REQ-020); any other funct yields 0.
REQ-017 Arithmetic SHALL be 32-bit modulo 2^32; overflow ignored.
REQ-018 dst_addr = RdAddr_b1 when Reg_dst=1, else RtAddr_b.
REQ-019 Non-mult instructions: EX/MEM outputs update every cycle; latency 1 cycle; ex_busy=0.
REQ-020 Multiply FSM states IDLE, BUSY, DONE; 32-iteration shift-add, result = low 32 bits of the unsigned product of the forwarded operands.
REQ-021 IDLE with mult decoded: latch operands, clear the 5-bit counter, go BUSY; ex_busy=1 combinationally this cycle; EX/MEM captures a bubble (mem_ctrl=000, other outputs 0).
REQ-022 BUSY: one iteration per cycle, counter increments; after the iteration with counter=31 go DONE; ex_busy=1; EX/MEM captures bubbles.
REQ-023 DONE: ex_busy=0; EX/MEM captures product, mem_ctrl, dst_addr, zero_flag; go IDLE; no retrigger on the same held instruction.
REQ-024 ex_busy SHALL be high for exactly 33 consecutive cycles per mult; the result appears on alu_result 34 edges after the mult enters EX.
REQ-025 Forwarding during BUSY SHALL NOT alter latched operands; WB writes may proceed.

Reset
REQ-026 rst_n low SHALL immediately force mem_ctrl=000, alu_result=0, store_data=0, dst_addr=0, zero_flag=0, FSM=IDLE, counter=0, ex_busy=0; any in-flight multiply is discarded.
REQ-027 After release, the first rising edge behaves as a normal IDLE cycle.

Configuration
REQ-028 Macro MULT_UNIT_EN: when defined, REQ-020..REQ-025 are built; when undefined, no FSM exists, funct 011000 yields alu_result 0 with 1-cycle latency, and ex_busy is constant 0.

Verification
REQ-029 add: Rs=5, Rt=7, ALU_op=10, funct=100000, Reg_dst=1, Rd=3 -> next edge alu_result=12, dst_addr=3, mem_ctrl=100.
REQ-030 Back-to-back dependency: add r3=12, then sub r4=r3-r1 (r1=2, register-file r3=0) -> second alu_result=10 via EX/MEM forwarding; with only wb_addr=3, wb_data=9 -> 7.
REQ-031 lw with imm=0xFFFC, Rs=0x100, ALU_src=1, ALU_op=00 -> alu_result=0xFC, mem_ctrl=101, dst_addr=Rt.
REQ-032 mult 0xFFFFFFFF*3 (MULT_UNIT_EN) -> ex_busy high 33 cycles, bubbles meanwhile, then alu_result=0xFFFFFFFD.
REQ-033 rst_n pulsed low at BUSY counter=10 -> outputs 0 and ex_busy=0 immediately; a subsequent add completes normally.
REQ-034 Build without MULT_UNIT_EN, issue mult -> ex_busy never asserts, alu_result=0 after 1 cycle.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage -- MIPS-style execute stage with operand forwarding and an
// optional iterative shift-add multiplier.
//
// Optional feature: define MULT_UNIT_EN to build the multiplier FSM
// (funct 011000). Without it, funct 011000 yields 0 with 1-cycle latency
// and ex_busy is tied low.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   contral_out_b1    ID/EX control {ALU_src, Reg_dst, Reg_w, Mem_w, Mem_r, ALU_op[1:0]}
//   RsData_b          register-file Rs operand
//   RtData_b1         register-file Rt operand
//   ALU_something     16-bit immediate, [5:0] is funct
//   RdAddr_b1, RtAddr_b, RsAddr_b   register addresses
//   wb_reg_w, wb_addr, wb_data      MEM/WB write-back, used for forwarding
//   ex_busy           stall request to upstream stages
//   mem_ctrl          registered {Reg_w, Mem_w, Mem_r}
//   alu_result        registered ALU / multiply result
//   store_data        registered forwarded Rt value
//   dst_addr          registered destination register
//   zero_flag         registered (result == 0)
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  contral_out_b1,
  input  logic [31:0] RsData_b,
  input  logic [31:0] RtData_b1,
  input  logic [15:0] ALU_something,
  input  logic [4:0]  RdAddr_b1,
  input  logic [4:0]  RtAddr_b,
  input  logic [4:0]  RsAddr_b,
  input  logic        wb_reg_w,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_busy,
  output logic [2:0]  mem_ctrl,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [4:0]  dst_addr,
  output logic        zero_flag
);

  logic       alu_src;
  logic       reg_dst;
  logic [2:0] mem_bits;
  logic [1:0] alu_op;
  logic [5:0] funct;

  assign alu_src  = contral_out_b1[6];
  assign reg_dst  = contral_out_b1[5];
  assign mem_bits = contral_out_b1[4:2];
  assign alu_op   = contral_out_b1[1:0];
  assign funct    = ALU_something[5:0];

  // EX/MEM result has priority over MEM/WB; register 0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] rf_val,
    input logic        exm_w,
    input logic [4:0]  exm_addr,
    input logic [31:0] exm_val,
    input logic        wbk_w,
    input logic [4:0]  wbk_addr,
    input logic [31:0] wbk_val
  );
    logic [31:0] r;
    r = rf_val;
    if (exm_w && (exm_addr != 5'd0) && (exm_addr == addr))
      r = exm_val;
    else if (wbk_w && (wbk_addr != 5'd0) && (wbk_addr == addr))
      r = wbk_val;
    return r;
  endfunction

  // Modulo-2^32 ALU; unknown funct codes (including mult) produce 0.
  function automatic logic [31:0] alu_calc(
    input logic [1:0]         op,
    input logic [5:0]         fn,
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic [31:0] r;
    r = '0;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b11: r = {31'b0, (a < b)};
      default: begin
        case (fn)
          6'b100000: r = a + b;
          6'b100010: r = a - b;
          6'b100100: r = a & b;
          6'b100101: r = a | b;
          6'b101010: r = {31'b0, (a < b)};
          default:   r = '0;
        endcase
      end
    endcase
    return r;
  endfunction

  // ---- stage p0: forwarding, operand select, ALU ----
  logic [31:0] op_a_p0;
  logic [31:0] rt_fwd_p0;
  logic [31:0] op_b_p0;
  logic [31:0] alu_res_p0;
  logic [4:0]  dst_p0;

  assign op_a_p0    = fwd_sel(RsAddr_b, RsData_b, mem_ctrl[2], dst_addr, alu_result,
                              wb_reg_w, wb_addr, wb_data);
  assign rt_fwd_p0  = fwd_sel(RtAddr_b, RtData_b1, mem_ctrl[2], dst_addr, alu_result,
                              wb_reg_w, wb_addr, wb_data);
  assign op_b_p0    = alu_src ? {{16{ALU_something[15]}}, ALU_something} : rt_fwd_p0;
  assign alu_res_p0 = alu_calc(alu_op, funct, op_a_p0, op_b_p0);
  assign dst_p0     = reg_dst ? RdAddr_b1 : RtAddr_b;

`ifdef MULT_UNIT_EN
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] mcand_p1;
  logic [31:0] mplier_p1;
  logic [31:0] prod_p1;
  logic        is_mult_p0;
  logic        busy_p0;

  assign is_mult_p0 = (alu_op == 2'b10) && (funct == 6'b011000);
  // Busy already in the IDLE cycle that accepts the mult so upstream holds.
  assign busy_p0    = ((state == IDLE) && is_mult_p0) || (state == BUSY);
  assign ex_busy    = rst_n & busy_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: if (is_mult_p0) begin
          state <= BUSY;
          cnt   <= 5'd0;
        end
        BUSY: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DONE;
        end
        // DONE always returns to IDLE, so the held mult cannot retrigger.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: shift-add datapath, operands frozen once latched ----
  always_ff @(posedge clk) begin
    if ((state == IDLE) && is_mult_p0) begin
      mcand_p1  <= op_a_p0;
      mplier_p1 <= op_b_p0;
      prod_p1   <= '0;
    end else if (state == BUSY) begin
      if (mplier_p1[0]) prod_p1 <= prod_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end
`else
  assign ex_busy = 1'b0;
`endif

  logic [2:0]  nxt_ctrl;
  logic [31:0] nxt_res;
  logic [31:0] nxt_st;
  logic [4:0]  nxt_dst;
  logic        nxt_zero;

  always_comb begin
    nxt_ctrl = mem_bits;
    nxt_res  = alu_res_p0;
    nxt_st   = rt_fwd_p0;
    nxt_dst  = dst_p0;
    nxt_zero = (alu_res_p0 == '0);
`ifdef MULT_UNIT_EN
    if (state == DONE) begin
      nxt_res  = prod_p1;
      nxt_zero = (prod_p1 == '0);
    end else if (busy_p0) begin
      nxt_ctrl = 3'b000;
      nxt_res  = '0;
      nxt_st   = '0;
      nxt_dst  = 5'd0;
      nxt_zero = 1'b0;
    end
`endif
  end

  // ---- EX/MEM register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl   <= 3'b000;
      alu_result <= '0;
      store_data <= '0;
      dst_addr   <= 5'd0;
      zero_flag  <= 1'b0;
    end else begin
      mem_ctrl   <= nxt_ctrl;
      alu_result <= nxt_res;
      store_data <= nxt_st;
      dst_addr   <= nxt_dst;
      zero_flag  <= nxt_zero;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- randomized self-checking bench for ex_stage with a
// behavioural EX/MEM model. Mult expectations follow MULT_UNIT_EN.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  ctrl;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm;
  logic [4:0]  rd_addr, rt_addr, rs_addr;
  logic        wb_reg_w;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_busy;
  logic [2:0]  mem_ctrl;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dst_addr;
  logic        zero_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .contral_out_b1(ctrl),
    .RsData_b(rs_data), .RtData_b1(rt_data), .ALU_something(imm),
    .RdAddr_b1(rd_addr), .RtAddr_b(rt_addr), .RsAddr_b(rs_addr),
    .wb_reg_w(wb_reg_w), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_busy(ex_busy), .mem_ctrl(mem_ctrl), .alu_result(alu_result),
    .store_data(store_data), .dst_addr(dst_addr), .zero_flag(zero_flag)
  );

  // Model of the EX/MEM register and of the multiply in flight.
  logic [2:0]  m_ctrl;
  logic [31:0] m_res, m_st;
  logic [4:0]  m_dst;
  logic        m_z;
  int          phase;      // 0: no mult; 1..33: cycles since mult accepted
  logic [31:0] m_prod;
  int          busy_seen;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 3'b000; m_res = '0; m_st = '0; m_dst = 5'd0; m_z = 1'b0;
    phase = 0; m_prod = '0;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (m_ctrl[2] && m_dst != 5'd0 && m_dst == a) return m_res;
    if (wb_reg_w && wb_addr != 5'd0 && wb_addr == a) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] slt;
    slt = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return slt;
      default: case (f)
        6'h20:   return a + b;
        6'h22:   return a - b;
        6'h24:   return a & b;
        6'h25:   return a | b;
        6'h2a:   return slt;
        default: return 32'd0;
      endcase
    endcase
  endfunction

  // Called just after inputs are driven at the falling edge; checks the
  // combinational stall, then the registered outputs after the rising edge.
  task automatic run_cycle();
    logic [31:0] a, fb, b, r, n_res, n_st;
    logic [2:0]  n_ctrl;
    logic [4:0]  n_dst;
    logic        n_z, mul, eb;
    #1;
    a   = fwd(rs_addr, rs_data);
    fb  = fwd(rt_addr, rt_data);
    b   = ctrl[6] ? {{16{imm[15]}}, imm} : fb;
    mul = (ctrl[1:0] == 2'b10) && (imm[5:0] == 6'h18);
    r   = ref_alu(ctrl[1:0], imm[5:0], a, b);
    n_ctrl = ctrl[4:2]; n_res = r; n_st = fb;
    n_dst  = ctrl[5] ? rd_addr : rt_addr; n_z = (r == 32'd0);
    eb = 1'b0;
`ifdef MULT_UNIT_EN
    if (phase == 0 && mul) begin
      m_prod = a * b; phase = 1; eb = 1'b1;
    end else if (phase >= 1 && phase <= 32) begin
      phase++; eb = 1'b1;
    end else if (phase == 33) begin
      n_res = m_prod; n_z = (m_prod == 32'd0); phase = 0;
    end
    if (eb) begin
      n_ctrl = 3'b000; n_res = '0; n_st = '0; n_dst = 5'd0; n_z = 1'b0;
    end
`else
    if (mul) n_res = 32'd0;
`endif
    chk_eq("ex_busy", 32'(ex_busy), 32'(eb));
    if (ex_busy) busy_seen++;
    @(posedge clk); #1;
    m_ctrl = n_ctrl; m_res = n_res; m_st = n_st; m_dst = n_dst; m_z = n_z;
    chk_eq("mem_ctrl",   32'(mem_ctrl),  32'(m_ctrl));
    chk_eq("alu_result", alu_result,     m_res);
    chk_eq("store_data", store_data,     m_st);
    chk_eq("dst_addr",   32'(dst_addr),  32'(m_dst));
    chk_eq("zero_flag",  32'(zero_flag), 32'(m_z));
  endtask

  task automatic set_instr(input logic [6:0] c, input logic [15:0] im,
                           input logic [4:0] rsa, input logic [31:0] rsd,
                           input logic [4:0] rta, input logic [31:0] rtd,
                           input logic [4:0] rda);
    ctrl = c; imm = im; rs_addr = rsa; rs_data = rsd;
    rt_addr = rta; rt_data = rtd; rd_addr = rda;
  endtask

  task automatic rand_instr();
    logic [5:0] functs [5];
    int sel;
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    sel  = $urandom_range(0, 9);
    ctrl = 7'($urandom);
    imm  = 16'($urandom);
    ctrl[1:0] = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
    if (sel >= 3 && sel <= 7) imm[5:0] = functs[sel-3];
    if (sel == 9) begin imm[5:0] = 6'h18; ctrl[6] = 1'b0; end
    rs_addr = 5'($urandom_range(0, 7));
    rt_addr = 5'($urandom_range(0, 7));
    rd_addr = 5'($urandom_range(0, 7));
    rs_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
    rt_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
  endtask

  initial begin
    rst_n = 1'b1;
    set_instr(7'd0, 16'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0);
    wb_reg_w = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    busy_seen = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #20;
    chk_eq("rst_mem_ctrl",   32'(mem_ctrl),  32'd0);
    chk_eq("rst_alu_result", alu_result,     32'd0);
    chk_eq("rst_store_data", store_data,     32'd0);
    chk_eq("rst_dst_addr",   32'(dst_addr),  32'd0);
    chk_eq("rst_zero_flag",  32'(zero_flag), 32'd0);
    chk_eq("rst_ex_busy",    32'(ex_busy),   32'd0);

    // add r3 = 5 + 7
    @(negedge clk); rst_n = 1'b1;
    set_instr(7'b0110010, 16'h0020, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
    run_cycle();
    chk_eq("add_res", alu_result, 32'd12);
    chk_eq("add_dst", 32'(dst_addr), 32'd3);
    chk_eq("add_ctrl", 32'(mem_ctrl), 32'b100);

    // sub r4 = r3 - r1 via EX/MEM forwarding
    @(negedge clk);
    set_instr(7'b0110010, 16'h0022, 5'd3, 32'd0, 5'd1, 32'd2, 5'd4);
    run_cycle();
    chk_eq("fwd_exmem", alu_result, 32'd10);

    // bubble-like op with Reg_w=0, then sub with only MEM/WB forwarding
    @(negedge clk);
    set_instr(7'b0000010, 16'h0020, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0);
    run_cycle();
    @(negedge clk);
    set_instr(7'b0110010, 16'h0022, 5'd3, 32'd0, 5'd1, 32'd2, 5'd4);
    wb_reg_w = 1'b1; wb_addr = 5'd3; wb_data = 32'd9;
    run_cycle();
    chk_eq("fwd_wb", alu_result, 32'd7);

    // lw with negative offset
    @(negedge clk);
    wb_reg_w = 1'b0;
    set_instr(7'b1010100, 16'hFFFC, 5'd5, 32'h100, 5'd6, 32'd0, 5'd9);
    run_cycle();
    chk_eq("lw_res", alu_result, 32'h0000_00FC);
    chk_eq("lw_ctrl", 32'(mem_ctrl), 32'b101);
    chk_eq("lw_dst", 32'(dst_addr), 32'd6);

    // mult 0xFFFFFFFF * 3, WB activity on the Rs register while busy
    @(negedge clk);
    set_instr(7'b0110010, 16'h0018, 5'd7, 32'hFFFF_FFFF, 5'd8, 32'd3, 5'd10);
    busy_seen = 0;
    run_cycle();
`ifdef MULT_UNIT_EN
    repeat (33) begin
      @(negedge clk);
      wb_reg_w = 1'b1; wb_addr = 5'd7; wb_data = $urandom;
      run_cycle();
    end
    wb_reg_w = 1'b0;
    chk_eq("mult_busy_cycles", 32'(busy_seen), 32'd33);
    chk_eq("mult_res", alu_result, 32'hFFFF_FFFD);
    chk_eq("mult_dst", 32'(dst_addr), 32'd10);

    // reset while BUSY with counter at 10
    @(negedge clk);
    set_instr(7'b0110010, 16'h0018, 5'd7, 32'd6, 5'd8, 32'd7, 5'd11);
    run_cycle();
    repeat (10) begin @(negedge clk); run_cycle(); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("midrst_ex_busy",    32'(ex_busy),   32'd0);
    chk_eq("midrst_mem_ctrl",   32'(mem_ctrl),  32'd0);
    chk_eq("midrst_alu_result", alu_result,     32'd0);
    chk_eq("midrst_dst_addr",   32'(dst_addr),  32'd0);
    chk_eq("midrst_zero_flag",  32'(zero_flag), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    set_instr(7'b0110010, 16'h0020, 5'd1, 32'd20, 5'd2, 32'd22, 5'd5);
    run_cycle();
    chk_eq("post_rst_add", alu_result, 32'd42);
`else
    chk_eq("nomult_busy", 32'(busy_seen), 32'd0);
    chk_eq("nomult_res", alu_result, 32'd0);
`endif

    // randomized traffic; upstream holds the instruction while stalled
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (phase == 0) rand_instr();
      wb_reg_w = 1'($urandom_range(0, 1));
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
